// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: floating-point register file with per-register pending (scoreboard) bits.
// Three read ports plus a debug read port; write port A for single-cycle results,
// write port B for multi-cycle div/sqrt writeback, which also retires pending bits.
// Optional feature macro: FREG_BYPASS_EN (same-cycle write-to-read forwarding on rs1/rs2/rs3).
module fp_regfile_sb #(
   parameter int unsigned FLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic [AW-1:0]   iRs1,
   input  logic [AW-1:0]   iRs2,
   input  logic [AW-1:0]   iRs3,
   output logic [FLEN-1:0] oRd1,
   output logic [FLEN-1:0] oRd2,
   output logic [FLEN-1:0] oRd3,
   output logic            oBusy1,
   output logic            oBusy2,
   output logic            oBusy3,
   input  logic            iWeA,
   input  logic [AW-1:0]   iWaddrA,
   input  logic [FLEN-1:0] iWdataA,
   input  logic            iWspA,
   input  logic            iWeB,
   input  logic [AW-1:0]   iWaddrB,
   input  logic [FLEN-1:0] iWdataB,
   input  logic            iWspB,
   input  logic            iIssue,
   input  logic [AW-1:0]   iIssueRd,
   output logic            oWrConflict,
   input  logic [AW-1:0]   iVGASelect,
   output logic [FLEN-1:0] oVGARead
);

   localparam int unsigned NPORTS = 3;

   logic [FLEN-1:0] regs_q [NREGS];
   logic [FLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] pend_q, pend_d;
   logic             conflict_q, conflict_d;

   logic [FLEN-1:0] wdata_a_box, wdata_b_box;

   // NaN-box single-precision write data into the upper half when registers are 64 bits wide
   generate
      if (FLEN == 64) begin : g_box
         assign wdata_a_box = iWspA ? {32'hFFFF_FFFF, iWdataA[31:0]} : iWdataA;
         assign wdata_b_box = iWspB ? {32'hFFFF_FFFF, iWdataB[31:0]} : iWdataB;
      end else begin : g_nobox
         logic unused_sp;
         assign unused_sp   = iWspA | iWspB;
         assign wdata_a_box = iWdataA;
         assign wdata_b_box = iWdataB;
      end
   endgenerate

   // Next register contents: B first, then A, so A wins an address collision
   always_comb begin
      for (int i = 0; i < int'(NREGS); i++) begin
         regs_d[i] = regs_q[i];
         if (iWeB && (iWaddrB == AW'(i))) regs_d[i] = wdata_b_box;
         if (iWeA && (iWaddrA == AW'(i))) regs_d[i] = wdata_a_box;
      end
   end

   // Next pending bits: B writeback clears, issue sets; set wins when both hit one register
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (iWeB && (iWaddrB == AW'(i)))     pend_d[i] = 1'b0;
         if (iIssue && (iIssueRd == AW'(i)))  pend_d[i] = 1'b1;
      end
   end

   // Flag a dropped port-B write caused by both ports targeting the same register
   always_comb begin
      conflict_d = iWeA && iWeB && (iWaddrA == iWaddrB);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
         pend_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= regs_d[i];
         pend_q     <= pend_d;
         conflict_q <= conflict_d;
      end
   end

   assign oWrConflict = conflict_q;
   assign oVGARead    = regs_q[iVGASelect];

   logic [AW-1:0]   rs_c   [NPORTS];
   logic [FLEN-1:0] rd_c   [NPORTS];
   logic            busy_c [NPORTS];

   assign rs_c[0] = iRs1;
   assign rs_c[1] = iRs2;
   assign rs_c[2] = iRs3;

   // Read ports: stored data and pending bit, optionally forwarded from this cycle's writes
   always_comb begin
      for (int p = 0; p < int'(NPORTS); p++) begin
         rd_c[p]   = regs_q[rs_c[p]];
         busy_c[p] = pend_q[rs_c[p]];
`ifdef FREG_BYPASS_EN
         if (iWeB && (iWaddrB == rs_c[p])) begin
            rd_c[p]   = wdata_b_box;
            busy_c[p] = 1'b0;
         end
         if (iWeA && (iWaddrA == rs_c[p])) begin
            rd_c[p] = wdata_a_box;
         end
`endif
      end
   end

   assign oRd1   = rd_c[0];
   assign oRd2   = rd_c[1];
   assign oRd3   = rd_c[2];
   assign oBusy1 = busy_c[0];
   assign oBusy2 = busy_c[1];
   assign oBusy3 = busy_c[2];

endmodule
